// File: rtl/i2c_slave_mem.sv
// rtl/i2c_slave_mem.sv - I2C responder with byte-wide memory and auto-incrementing pointer
//
// Ports:
//   clk      system clock (>= 8x SCL rate)
//   resetn   asynchronous active-low reset
//   scl_i    SCL line level from pad
//   sda_i    SDA line level from pad
//   sda_oe   1 = pull SDA low, 0 = release
//   busy     1 from an addressed START until the next STOP
//   wr_stb   one-cycle pulse per byte written to memory
//   wr_addr  memory address of the write (valid with wr_stb)
//   wr_data  byte written (valid with wr_stb)
`timescale 1ns/1ps
module i2c_slave_mem #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         DEPTH      = 256,
    parameter int         FILTER_LEN = 3
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_oe,
    output logic                     busy,
    output logic                     wr_stb,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic [7:0]               wr_data
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_t;

    // Input conditioning: 2-FF synchronizer, then a level is accepted only
    // after FILTER_LEN identical samples. Everything presets to the idle bus.
    logic [1:0]            scl_sync, sda_sync;
    logic [FILTER_LEN-1:0] scl_hist, sda_hist;
    logic                  scl_f, sda_f, scl_d, sda_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_hist <= FILTER_LEN'({scl_hist, scl_sync[1]});
            sda_hist <= FILTER_LEN'({sda_hist, sda_sync[1]});
            if (&scl_hist)
                scl_f <= 1'b1;
            else if (~|scl_hist)
                scl_f <= 1'b0;
            if (&sda_hist)
                sda_f <= 1'b1;
            else if (~|sda_hist)
                sda_f <= 1'b0;
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    logic scl_rise, scl_fall, start_c, stop_c;
    assign scl_rise = scl_f & ~scl_d;
    assign scl_fall = ~scl_f & scl_d;
    assign start_c  = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_c   = scl_f & scl_d & ~sda_d & sda_f;

    // Memory is written one cycle after the strobe; reads happen many clocks
    // later (next SCL fall at the earliest), so the lag is never visible.
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_stb)
            mem[wr_addr] <= wr_data;
    end

    state_t      state;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_sh;
    logic [6:0]  tx_sh;
    logic        rw;
    logic [1:0]  ack_ph;
    logic [PW-1:0] ptr;

    logic [7:0]    rx_byte;
    logic [7:0]    rd_byte;
    logic [PW-1:0] ptr_next;

    assign rx_byte  = {rx_sh, sda_f};
    assign rd_byte  = mem[ptr];
    assign ptr_next = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            ptr     <= '0;
            bit_cnt <= '0;
            rx_sh   <= '0;
            tx_sh   <= '0;
            rw      <= 1'b0;
            ack_ph  <= '0;
        end else begin
            wr_stb <= 1'b0;
            // Bus conditions abort whatever byte is in flight; partial bytes
            // never reach memory or the pointer.
            if (stop_c) begin
                state   <= IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                bit_cnt <= '0;
            end else if (start_c) begin
                state   <= ADDR;
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        sda_oe <= 1'b0;
                    end
                    ADDR, PTR, WDATA: begin
                        if (scl_rise) begin
                            rx_sh   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ack_ph <= 2'd0;
                                if (state == ADDR) begin
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        state <= ADDR_ACK;
                                        rw    <= rx_byte[0];
                                        busy  <= 1'b1;
                                    end else begin
                                        state <= IGNORE;
                                    end
                                end else if (state == PTR) begin
                                    ptr   <= PW'(32'(rx_byte) % DEPTH);
                                    state <= PTR_ACK;
                                end else begin
                                    wr_stb  <= 1'b1;
                                    wr_addr <= ptr;
                                    wr_data <= rx_byte;
                                    ptr     <= ptr_next;
                                    state   <= WDATA_ACK;
                                end
                            end
                        end
                    end
                    // First SCL fall after the 8th bit pulls SDA; the second
                    // releases it and starts the next byte.
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            if (ack_ph == 2'd0) begin
                                sda_oe <= 1'b1;
                                ack_ph <= 2'd1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                if (state == ADDR_ACK && rw) begin
                                    tx_sh  <= rd_byte[6:0];
                                    sda_oe <= ~rd_byte[7];
                                    state  <= RDATA;
                                end else if (state == ADDR_ACK) begin
                                    state <= PTR;
                                end else begin
                                    state <= WDATA;
                                end
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ptr    <= ptr_next;
                                ack_ph <= 2'd0;
                                state  <= RDATA_ACK;
                            end
                        end else if (scl_fall) begin
                            sda_oe <= ~tx_sh[6];
                            tx_sh  <= {tx_sh[5:0], 1'b0};
                        end
                    end
                    // ph0: release SDA for the master's ACK bit; ph1: sample it;
                    // ph2: on the following fall present the next byte's MSB.
                    RDATA_ACK: begin
                        if (ack_ph == 2'd0) begin
                            if (scl_fall) begin
                                sda_oe <= 1'b0;
                                ack_ph <= 2'd1;
                            end
                        end else if (ack_ph == 2'd1) begin
                            if (scl_rise) begin
                                if (sda_f)
                                    state <= IGNORE;
                                else
                                    ack_ph <= 2'd2;
                            end
                        end else if (scl_fall) begin
                            tx_sh   <= rd_byte[6:0];
                            sda_oe  <= ~rd_byte[7];
                            bit_cnt <= '0;
                            state   <= RDATA;
                        end
                    end
                    IGNORE: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_mem.sv
// tb/tb_i2c_slave_mem.sv - self-checking bench for i2c_slave_mem
`timescale 1ns/1ps
module tb_i2c_slave_mem;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       resetn;
    logic       scl;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic       busy;
    logic       wr_stb;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_mem #(
        .DEV_ADDR  (7'h50),
        .DEPTH     (256),
        .FILTER_LEN(3)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .scl_i  (scl),
        .sda_i  (sda_line),
        .sda_oe (sda_oe),
        .busy   (busy),
        .wr_stb (wr_stb),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        int             kind;   // 0 = write, 1 = set ptr then read
        logic [6:0]     dev;
        logic [7:0]     ptr;
        int             n;
        logic [3:0][7:0] d;
        logic           ack;
    } vec_t;

    vec_t vecs[8];

    logic oe_seen;
    logic busy_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
        if (resetn && wr_stb) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr: got addr %0h data %0h expected no write", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.a));
                check("wr_data", 32'(wr_data), 32'(e.d));
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clks(Q);
        scl   = 1'b1; wait_clks(Q);
        sda_m = 1'b0; wait_clks(Q);
        scl   = 1'b0; wait_clks(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clks(Q);
        scl   = 1'b1; wait_clks(Q);
        sda_m = 1'b1; wait_clks(2 * Q);
    endtask

    // Optional 1-clk inverted SDA pulse in the middle of the SCL-high phase.
    task automatic put_bit(input logic b, input logic g);
        sda_m = b; wait_clks(Q);
        scl   = 1'b1; wait_clks(Q);
        if (g) begin
            sda_m = ~b; wait_clks(1);
            sda_m = b;  wait_clks(Q - 1);
        end else begin
            wait_clks(Q);
        end
        scl = 1'b0; wait_clks(Q);
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; wait_clks(Q);
        scl   = 1'b1; wait_clks(Q);
        b     = sda_line; wait_clks(Q);
        scl   = 1'b0; wait_clks(Q);
    endtask

    task automatic send_byte(input logic [7:0] v, input logic g, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--)
            put_bit(v[i], g);
        get_bit(a);
        ack = ~a;
    endtask

    task automatic recv_byte(input logic ack_it, output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            v[i] = b;
        end
        put_bit(~ack_it, 1'b0);
    endtask

    function automatic vec_t mk(input int kind, input logic [6:0] dev, input logic [7:0] ptr,
                                input int n, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3, input logic ack);
        vec_t v;
        v.kind = kind;
        v.dev  = dev;
        v.ptr  = ptr;
        v.n    = n;
        v.d[0] = b0;
        v.d[1] = b1;
        v.d[2] = b2;
        v.d[3] = b3;
        v.ack  = ack;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        logic       a;
        logic [7:0] rb;
        oe_seen   = 1'b0;
        busy_seen = 1'b0;
        i2c_start();
        send_byte({v.dev, 1'b0}, 1'b0, a);
        check("addr_ack", 32'(a), 32'(v.ack));
        if (v.ack) check("busy_set", 32'(busy), 32'd1);
        send_byte(v.ptr, 1'b0, a);
        check("ptr_ack", 32'(a), 32'(v.ack));
        if (v.kind == 0) begin
            for (int i = 0; i < v.n; i++) begin
                if (v.ack) expect_wr(8'(v.ptr + 8'(i)), v.d[i]);
                send_byte(v.d[i], 1'b0, a);
                check("data_ack", 32'(a), 32'(v.ack));
            end
        end else begin
            i2c_start();
            send_byte({v.dev, 1'b1}, 1'b0, a);
            check("raddr_ack", 32'(a), 32'(v.ack));
            for (int i = 0; i < v.n; i++) begin
                recv_byte(i != v.n - 1, rb);
                check("rd_data", 32'(rb), 32'(v.d[i]));
            end
            check("rel_after_nack", 32'(sda_oe), 32'd0);
        end
        i2c_stop();
        check("busy_clr", 32'(busy), 32'd0);
        if (!v.ack) begin
            check("no_ack_oe", 32'(oe_seen), 32'd0);
            check("no_ack_busy", 32'(busy_seen), 32'd0);
        end
    endtask

    initial begin
        logic       a;
        logic [7:0] rb;

        vecs[0] = mk(0, 7'h50, 8'h10, 2, 8'hA5, 8'h3C, 8'h00, 8'h00, 1'b1);
        vecs[1] = mk(1, 7'h50, 8'h10, 2, 8'hA5, 8'h3C, 8'h00, 8'h00, 1'b1);
        vecs[2] = mk(0, 7'h51, 8'h10, 1, 8'h77, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[3] = mk(0, 7'h50, 8'hFF, 2, 8'h11, 8'h22, 8'h00, 8'h00, 1'b1);
        vecs[4] = mk(1, 7'h50, 8'hFF, 2, 8'h11, 8'h22, 8'h00, 8'h00, 1'b1);
        vecs[5] = mk(0, 7'h50, 8'h80, 4, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b1);
        vecs[6] = mk(1, 7'h50, 8'h80, 4, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b1);
        vecs[7] = mk(1, 7'h50, 8'h10, 2, 8'hA5, 8'h3C, 8'h00, 8'h00, 1'b1);

        resetn = 1'b0;
        scl    = 1'b1;
        sda_m  = 1'b1;
        wait_clks(5);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_stb", 32'(wr_stb), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        resetn = 1'b1;
        wait_clks(10);

        for (int i = 0; i < 8; i++)
            run_vec(vecs[i]);

        // SDA glitches while SCL is high must not look like START/STOP.
        i2c_start();
        send_byte(8'hA0, 1'b0, a);
        check("gl_addr_ack", 32'(a), 32'd1);
        send_byte(8'h20, 1'b0, a);
        check("gl_ptr_ack", 32'(a), 32'd1);
        expect_wr(8'h20, 8'h81);
        send_byte(8'h81, 1'b1, a);
        check("gl_data_ack", 32'(a), 32'd1);
        i2c_stop();

        // Partial byte aborted by STOP: no write, pointer stays at 0x41.
        i2c_start();
        send_byte(8'hA0, 1'b0, a);
        send_byte(8'h40, 1'b0, a);
        expect_wr(8'h40, 8'h55);
        send_byte(8'h55, 1'b0, a);
        expect_wr(8'h41, 8'h66);
        send_byte(8'h66, 1'b0, a);
        i2c_stop();
        i2c_start();
        send_byte(8'hA0, 1'b0, a);
        send_byte(8'h40, 1'b0, a);
        expect_wr(8'h40, 8'h99);
        send_byte(8'h99, 1'b0, a);
        put_bit(1'b1, 1'b0);
        put_bit(1'b0, 1'b0);
        put_bit(1'b1, 1'b0);
        put_bit(1'b0, 1'b0);
        i2c_stop();
        check("abort_no_wr", 32'(exp_q.size()), 32'd0);
        i2c_start();
        send_byte(8'hA1, 1'b0, a);
        check("abort_rd_ack", 32'(a), 32'd1);
        recv_byte(1'b0, rb);
        check("abort_ptr_kept", 32'(rb), 32'h66);
        i2c_stop();

        // Reset while the responder is driving a 0 data bit.
        i2c_start();
        send_byte(8'hA0, 1'b0, a);
        send_byte(8'h11, 1'b0, a);
        i2c_start();
        send_byte(8'hA1, 1'b0, a);
        check("rr_addr_ack", 32'(a), 32'd1);
        sda_m = 1'b1; wait_clks(Q);
        scl   = 1'b1; wait_clks(Q);
        check("rr_driving", 32'(sda_oe), 32'd1);
        resetn = 1'b0;
        #1;
        check("rr_async_oe", 32'(sda_oe), 32'd0);
        check("rr_async_busy", 32'(busy), 32'd0);
        check("rr_wr_data", 32'(wr_data), 32'd0);
        wait_clks(3);
        resetn = 1'b1;
        wait_clks(Q);
        scl = 1'b0; wait_clks(Q);
        i2c_stop();

        // Pointer reset to 0, memory kept: mem[0] = 0x22 from the wrap write.
        i2c_start();
        send_byte(8'hA1, 1'b0, a);
        check("post_rst_ack", 32'(a), 32'd1);
        recv_byte(1'b0, rb);
        check("post_rst_mem0", 32'(rb), 32'h22);
        i2c_stop();

        wait_clks(20);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
